// File: rtl/fp_mul_pipe.sv
// Pipelined IEEE-754-style multiplier: capture/classify, multiply, normalise/round, pack.
// Define FP_MUL_FLAGS_EN to add the {invalid, overflow, underflow, inexact} flag output.
module fp_mul_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [EXP_W+MAN_W:0] in_a_i,
    input  logic [EXP_W+MAN_W:0] in_b_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [EXP_W+MAN_W:0] out_res_o
`ifdef FP_MUL_FLAGS_EN
    ,
    output logic [3:0]           out_flags_o
`endif
);
    localparam int unsigned W    = 1 + EXP_W + MAN_W;
    localparam int unsigned EW   = EXP_W + 2;
    localparam int unsigned MW   = MAN_W + 1;
    localparam int unsigned PW   = 2 * MAN_W + 2;
    localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;

    localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]  QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

    logic en;

    // Special-case class carried down the pipe as {nan, inf, zero}
    logic             s1_valid_q, s1_sign_q;
    logic [EXP_W-1:0] s1_ea_q, s1_eb_q;
    logic [MW-1:0]    s1_ma_q, s1_mb_q;
    logic [2:0]       s1_cls_q, s1_cls_d;

    logic             s2_valid_q, s2_sign_q;
    logic [EW-1:0]    s2_exp_q, s2_exp_d;
    logic [PW-1:0]    s2_prod_q, s2_prod_d;
    logic [2:0]       s2_cls_q;

    logic             s3_valid_q, s3_sign_q;
    logic [EW-1:0]    s3_exp_q, s3_exp_d;
    logic [MAN_W-1:0] s3_frac_q, s3_frac_d;
    logic [2:0]       s3_cls_q;

    logic             out_valid_q;
    logic [W-1:0]     out_res_q, out_res_d;

    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    logic [MAN_W-1:0] frac_n;
    logic [MAN_W:0]   frac_r;
    logic             guard, sticky;
    logic [EW-1:0]    exp_n;
    logic             ovf, unf;

    assign en          = !(out_valid_q && !out_ready_i);
    assign in_ready_o  = en;
    assign out_valid_o = out_valid_q;
    assign out_res_o   = out_res_q;

    // Stage 1: unpack and classify; subnormal operands are flushed to zero
    always_comb begin
        ea     = in_a_i[W-2 -: EXP_W];
        eb     = in_b_i[W-2 -: EXP_W];
        fa     = in_a_i[MAN_W-1:0];
        fb     = in_b_i[MAN_W-1:0];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (ea == '1) && (fa == '0);
        b_inf  = (eb == '1) && (fb == '0);
        a_nan  = (ea == '1) && (fa != '0);
        b_nan  = (eb == '1) && (fb != '0);
        s1_cls_d = 3'b000;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            s1_cls_d = 3'b100;
        end else if (a_inf || b_inf) begin
            s1_cls_d = 3'b010;
        end else if (a_zero || b_zero) begin
            s1_cls_d = 3'b001;
        end
    end

    // Stage 2: mantissa product and biased exponent sum, wide enough not to wrap
    always_comb begin
        s2_prod_d = PW'(s1_ma_q) * PW'(s1_mb_q);
        s2_exp_d  = EW'(s1_ea_q) + EW'(s1_eb_q) - EW'(BIAS);
    end

    // Stage 3: normalise, round to nearest even
    always_comb begin
        if (s2_prod_q[PW-1]) begin
            frac_n = s2_prod_q[PW-2 -: MAN_W];
            guard  = s2_prod_q[MAN_W];
            sticky = |s2_prod_q[MAN_W-1:0];
            exp_n  = s2_exp_q + EW'(1);
        end else begin
            frac_n = s2_prod_q[PW-3 -: MAN_W];
            guard  = s2_prod_q[MAN_W-1];
            sticky = |s2_prod_q[MAN_W-2:0];
            exp_n  = s2_exp_q;
        end
        frac_r    = {1'b0, frac_n} + MW'(guard && (sticky || frac_n[0]));
        s3_frac_d = frac_r[MAN_W-1:0];
        s3_exp_d  = frac_r[MAN_W] ? exp_n + EW'(1) : exp_n;
    end

    // Output stage: range check and pack
    always_comb begin
        ovf       = $signed(s3_exp_q) >= $signed(EXP_MAX);
        unf       = s3_exp_q[EW-1] || (s3_exp_q == '0);
        out_res_d = {s3_sign_q, s3_exp_q[EXP_W-1:0], s3_frac_q};
        if (s3_cls_q[2]) begin
            out_res_d = QNAN;
        end else if (s3_cls_q[1] || ovf) begin
            out_res_d = {s3_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (s3_cls_q[0] || unf) begin
            out_res_d = {s3_sign_q, {(W - 1){1'b0}}};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_ea_q     <= '0;
            s1_eb_q     <= '0;
            s1_ma_q     <= '0;
            s1_mb_q     <= '0;
            s1_cls_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_exp_q    <= '0;
            s2_prod_q   <= '0;
            s2_cls_q    <= '0;
            s3_valid_q  <= 1'b0;
            s3_sign_q   <= 1'b0;
            s3_exp_q    <= '0;
            s3_frac_q   <= '0;
            s3_cls_q    <= '0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
        end else if (en) begin
            s1_valid_q  <= in_valid_i;
            s1_sign_q   <= in_a_i[W-1] ^ in_b_i[W-1];
            s1_ea_q     <= ea;
            s1_eb_q     <= eb;
            s1_ma_q     <= {1'b1, fa};
            s1_mb_q     <= {1'b1, fb};
            s1_cls_q    <= s1_cls_d;
            s2_valid_q  <= s1_valid_q;
            s2_sign_q   <= s1_sign_q;
            s2_exp_q    <= s2_exp_d;
            s2_prod_q   <= s2_prod_d;
            s2_cls_q    <= s1_cls_q;
            s3_valid_q  <= s2_valid_q;
            s3_sign_q   <= s2_sign_q;
            s3_exp_q    <= s3_exp_d;
            s3_frac_q   <= s3_frac_d;
            s3_cls_q    <= s2_cls_q;
            out_valid_q <= s3_valid_q;
            out_res_q   <= out_res_d;
        end
    end

`ifdef FP_MUL_FLAGS_EN
    logic       s3_inexact_q, s3_inexact_d;
    logic       finite;
    logic [3:0] out_flags_q, out_flags_d;

    assign s3_inexact_d = guard || sticky;
    assign finite       = (s3_cls_q == 3'b000);
    // A finite product of normal operands is never exactly zero, so flushing it is inexact
    assign out_flags_d  = {s3_cls_q[2], finite && ovf, finite && unf,
                           finite && (ovf || unf || s3_inexact_q)};
    assign out_flags_o  = out_flags_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s3_inexact_q <= 1'b0;
            out_flags_q  <= '0;
        end else if (en) begin
            s3_inexact_q <= s3_inexact_d;
            out_flags_q  <= out_flags_d;
        end
    end
`endif

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe: directed corner cases, backpressure, random stream, reset.
module tb_fp_mul_pipe;
    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  flags;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_a, in_b, out_res;
    logic [3:0]  mon_flags;
`ifdef FP_MUL_FLAGS_EN
    logic [3:0]  out_flags;
    assign mon_flags = out_flags;
`else
    assign mon_flags = 4'b0000;
`endif

    int   n_asserts = 0;
    int   n_fail    = 0;
    rec_t exp_q[$];
    rec_t obs_q[$];
    logic [31:0] op_a[$];
    logic [31:0] op_b[$];
    rec_t        op_e[$];

    localparam int ND = 10;
    localparam logic [31:0] DIR_A [ND] = '{32'h3FC00000, 32'hC0000000, 32'h3F800001,
        32'h7F800000, 32'h7F000000, 32'h00800000, 32'h00000001, 32'hFF800000,
        32'h80000000, 32'h7F800001};
    localparam logic [31:0] DIR_B [ND] = '{32'h40000000, 32'h40400000, 32'h3F800001,
        32'h00000000, 32'h7F000000, 32'h00800000, 32'h3F800000, 32'h3F800000,
        32'h40000000, 32'h3F800000};
    localparam logic [31:0] DIR_R [ND] = '{32'h40400000, 32'hC0C00000, 32'h3F800002,
        32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h00000000, 32'hFF800000,
        32'h80000000, 32'h7FC00000};
    localparam logic [3:0]  DIR_F [ND] = '{4'b0000, 4'b0000, 4'b0001, 4'b1000, 4'b0101,
        4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b1000};

    fp_mul_pipe dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_a_i      (in_a),
        .in_b_i      (in_b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_res_o   (out_res)
`ifdef FP_MUL_FLAGS_EN
        ,
        .out_flags_o (out_flags)
`endif
    );

    always #5 clk = ~clk;

    // A result is transferred on the next rising edge when valid and ready are both high here
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) obs_q.push_back({out_res, mon_flags});
    end

    // Single-precision reference: exact integer product, then round half to even by remainder
    function automatic rec_t ref_mul(input logic [31:0] a, input logic [31:0] b);
        rec_t r;
        int ea, eb, e, sh;
        longint unsigned p, q, rem, half;
        logic s, za, zb, ia, ib, na, nb;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 23'h0);
        ib = (eb == 255) && (b[22:0] == 23'h0);
        na = (ea == 255) && (a[22:0] != 23'h0);
        nb = (eb == 255) && (b[22:0] != 23'h0);
        r.flags = 4'b0000;
        if (na || nb || (ia && zb) || (za && ib)) begin
            r.res = 32'h7FC00000;
            r.flags = 4'b1000;
        end else if (ia || ib) begin
            r.res = {s, 8'hFF, 23'h0};
        end else if (za || zb) begin
            r.res = {s, 31'h0};
        end else begin
            p  = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
            sh = (p >= (64'd1 << 47)) ? 24 : 23;
            e  = ea + eb - 127 + (sh - 23);
            q  = p >> sh;
            rem  = p - (q << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
            if (e >= 255) begin
                r.res = {s, 8'hFF, 23'h0};
                r.flags = 4'b0101;
            end else if (e <= 0) begin
                r.res = {s, 31'h0};
                r.flags = 4'b0011;
            end else begin
                r.res = {s, 8'(e), q[22:0]};
                r.flags = {3'b000, rem != 0};
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] f;
        int k;
        k = $urandom_range(0, 9);
        f = 23'($urandom);
        if (k == 0) e = 8'h00;
        else if (k == 1) e = 8'hFF;
        else if (k == 2) e = 8'($urandom_range(1, 254));
        else e = 8'($urandom_range(96, 158));
        if (k < 3 && $urandom_range(0, 1) == 0) f = 23'h0;
        return {1'($urandom), e, f};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_asserts++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_dir(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            op_a.push_back(DIR_A[i]);
            op_b.push_back(DIR_B[i]);
            op_e.push_back({DIR_R[i], DIR_F[i]});
        end
    endtask

    task automatic load_rand(input int n);
        logic [31:0] a, b;
        for (int i = 0; i < n; i++) begin
            a = rand_op();
            b = rand_op();
            op_a.push_back(a);
            op_b.push_back(b);
            op_e.push_back(ref_mul(a, b));
        end
    endtask

    // mode 0: always ready, 1: ready low on cycles 4-8, 2: random ready
    task automatic run_batch(input int mode);
        int idx = 0;
        int cyc = 0;
        logic prev_stall = 1'b0;
        logic [31:0] prev_res = 32'h0;
        while (idx < op_a.size() && cyc < 200) begin
            case (mode)
                1: out_ready = !(cyc >= 4 && cyc <= 8);
                2: out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b1;
            endcase
            in_valid = 1'b1;
            in_a = op_a[idx];
            in_b = op_b[idx];
            @(negedge clk);
            check("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (prev_stall) check("hold_res", out_res, prev_res);
            prev_stall = out_valid && !out_ready;
            prev_res = out_res;
            if (in_ready) begin
                exp_q.push_back(op_e[idx]);
                idx++;
            end
            tick();
            cyc++;
        end
        check("accepted", 32'(idx), 32'(op_a.size()));
        in_valid = 1'b0;
        out_ready = 1'b1;
        op_a.delete();
        op_b.delete();
        op_e.delete();
    endtask

    task automatic drain();
        int guard = 0;
        int n = 0;
        rec_t e, o;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (obs_q.size() < exp_q.size() && guard < 50) begin
            tick();
            guard++;
        end
        repeat (4) tick();
        check("result_count", 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check($sformatf("res[%0d]", n), o.res, e.res);
`ifdef FP_MUL_FLAGS_EN
            check($sformatf("flags[%0d]", n), 32'(o.flags), 32'(e.flags));
`endif
            n++;
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_a = 32'h0;
        in_b = 32'h0;
        #3;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_res", out_res, 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
`ifdef FP_MUL_FLAGS_EN
        check("rst_flags", 32'(out_flags), 32'h0);
`endif
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Latency: accept at edge N, result visible after edge N+3
        in_a = DIR_A[0];
        in_b = DIR_B[0];
        in_valid = 1'b1;
        @(negedge clk);
        check("lat_in_ready", 32'(in_ready), 32'h1);
        exp_q.push_back({DIR_R[0], DIR_F[0]});
        tick();
        in_valid = 1'b0;
        check("lat_n0", 32'(out_valid), 32'h0);
        tick();
        check("lat_n1", 32'(out_valid), 32'h0);
        tick();
        check("lat_n2", 32'(out_valid), 32'h0);
        tick();
        check("lat_n3_valid", 32'(out_valid), 32'h1);
        check("lat_n3_res", out_res, DIR_R[0]);
        drain();

        // Directed corner cases back to back
        load_dir(1, ND - 1);
        run_batch(0);
        drain();

        // Six ops with output backpressure
        load_dir(1, 6);
        run_batch(1);
        drain();

        // Random operands with random backpressure
        load_rand(24);
        run_batch(2);
        drain();

        // Reset with three operations in flight and the output stalled
        load_dir(1, 3);
        run_batch(0);
        out_ready = 1'b0;
        repeat (3) tick();
        check("pre_rst_valid", 32'(out_valid), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_res", out_res, 32'h0);
        repeat (2) tick();
        rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
        out_ready = 1'b1;
        repeat (10) tick();
        check("post_rst_stale", 32'(obs_q.size()), 32'h0);
        check("post_rst_valid", 32'(out_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
